// File: rtl/sevenseg_scan_dec.sv
// Purpose : decodes DIGITS scanned seven-segment fields into 4-bit codes once each field
//           has been seen unchanged for STABLE_CYCLES enabled samples (debounce / de-ghost).
// Latency : a pattern held with en=1 from cycle t appears on num/err at cycle t+STABLE_CYCLES;
//           upd and locked are registered alongside num.
// Flow    : no backpressure; en=0 freezes every register and forces upd low.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   en               sample enable
//   display          digit k in [7k+6:7k], bit 6 = segment g ... bit 0 = segment a
//   num              committed code of digit k in [4k+3:4k] (15 = blank, 14 = unrecognised)
//   err              bit k set when committed digit k is unrecognised
//   upd              one-cycle pulse when any committed num/err value changed
//   locked           every digit's stability count is saturated
module sevenseg_scan_dec #(
   parameter int DIGITS        = 4,
   parameter int STABLE_CYCLES = 4,
   parameter int ACTIVE_LOW    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic [7*DIGITS-1:0]   display,
   output logic [4*DIGITS-1:0]   num,
   output logic [DIGITS-1:0]     err,
   output logic                  upd,
   output logic                  locked
);

   localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

   logic [DIGITS-1:0][6:0] prev_q, prev_d;
   logic [DIGITS-1:0][7:0] cnt_q, cnt_d;
   logic [4*DIGITS-1:0]    num_q, num_d;
   logic [DIGITS-1:0]      err_q, err_d;
   logic                   upd_q, upd_d;
   logic                   locked_q, locked_d;

   // scratch values reused for each digit inside the combinational loop
   logic [6:0]             norm;
   logic [4:0]             dec;
   logic                   commit;
   logic                   all_sat;

   // returns {err, code} for a lit-high pattern ordered g..a
   function automatic logic [4:0] decode(input logic [6:0] p);
      logic [4:0] r;
      case (p)
         7'b0111111: r = 5'h00;
         7'b0000110: r = 5'h01;
         7'b1011011: r = 5'h02;
         7'b1001111: r = 5'h03;
         7'b1100110: r = 5'h04;
         7'b1101101: r = 5'h05;
         7'b1111101: r = 5'h06;
         7'b0000111: r = 5'h07;
         7'b1111111: r = 5'h08;
         7'b1100111: r = 5'h09;
         7'b0000000: r = 5'h0F;
         default:    r = 5'h1E;
      endcase
      return r;
   endfunction

   always_comb begin
      prev_d   = prev_q;
      cnt_d    = cnt_q;
      num_d    = num_q;
      err_d    = err_q;
      upd_d    = 1'b0;
      locked_d = locked_q;
      norm     = '0;
      dec      = '0;
      commit   = 1'b0;
      all_sat  = 1'b1;

      for (int k = 0; k < DIGITS; k++) begin
         norm   = (ACTIVE_LOW != 0) ? ~display[7*k +: 7] : display[7*k +: 7];
         commit = 1'b0;
         if (en) begin
            if (norm != prev_q[k]) begin
               prev_d[k] = norm;
               cnt_d[k]  = 8'd1;
               // a single-sample filter commits on every change
               commit    = (STABLE == 8'd1);
            end else if (cnt_q[k] != STABLE) begin
               cnt_d[k]  = cnt_q[k] + 8'd1;
               commit    = (cnt_d[k] == STABLE);
            end
         end
         if (commit) begin
            dec               = decode(norm);
            num_d[4*k +: 4]   = dec[3:0];
            err_d[k]          = dec[4];
            if (dec != {err_q[k], num_q[4*k +: 4]})
               upd_d = 1'b1;
         end
         all_sat = all_sat & (cnt_d[k] == STABLE);
      end

      if (en)
         locked_d = all_sat;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q   <= '0;
         cnt_q    <= '0;
         num_q    <= '1;
         err_q    <= '0;
         upd_q    <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         prev_q   <= prev_d;
         cnt_q    <= cnt_d;
         num_q    <= num_d;
         err_q    <= err_d;
         upd_q    <= upd_d;
         locked_q <= locked_d;
      end
   end

   assign num    = num_q;
   assign err    = err_q;
   assign upd    = upd_q;
   assign locked = locked_q;

endmodule

// File: tb/tb_sevenseg_scan_dec.sv
// Bench for sevenseg_scan_dec (DIGITS=4, STABLE_CYCLES=3, ACTIVE_LOW=1).
// The driver applies one directed vector per cycle and queues the outputs expected after
// that edge; the monitor pops one record per clock and compares num/err/upd/locked.
module tb_sevenseg_scan_dec;

   localparam int DIGITS = 4;

   localparam logic [6:0] B     = 7'h7F; // blank
   localparam logic [6:0] THREE = 7'h30;
   localparam logic [6:0] ZERO  = 7'h40;
   localparam logic [6:0] ONE   = 7'h79;
   localparam logic [6:0] EIGHT = 7'h00;
   localparam logic [6:0] BAD   = 7'h55;

   typedef struct packed {
      logic [15:0] num;
      logic [3:0]  err;
      logic        upd;
      logic        locked;
   } exp_t;

   logic                clk;
   logic                reset;
   logic                en;
   logic [7*DIGITS-1:0] display;
   logic [4*DIGITS-1:0] num;
   logic [DIGITS-1:0]   err;
   logic                upd;
   logic                locked;

   exp_t exp_q[$];
   int   checks = 0;
   int   fails  = 0;
   int   cyc    = 0;

   sevenseg_scan_dec #(
      .DIGITS        (DIGITS),
      .STABLE_CYCLES (3),
      .ACTIVE_LOW    (1)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .display (display),
      .num     (num),
      .err     (err),
      .upd     (upd),
      .locked  (locked)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s at record %0d: got %h expected %h", name, cyc, act, expv);
      end
   endtask

   // apply inputs for the coming edge and queue the outputs expected after it
   task automatic step(input logic r, input logic e,
                       input logic [6:0] d3, input logic [6:0] d2,
                       input logic [6:0] d1, input logic [6:0] d0,
                       input logic [15:0] n, input logic [3:0] er,
                       input logic u, input logic l);
      exp_t x;
      @(negedge clk);
      reset   = r;
      en      = e;
      display = {d3, d2, d1, d0};
      x.num = n; x.err = er; x.upd = u; x.locked = l;
      exp_q.push_back(x);
   endtask

   // monitor: one record per clock once the driver has started
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("num",    32'(num),    32'(x.num));
            chk("err",    32'(err),    32'(x.err));
            chk("upd",    32'(upd),    32'(x.upd));
            chk("locked", 32'(locked), 32'(x.locked));
            cyc++;
         end
      end
   end

   initial begin
      reset   = 1'b1;
      en      = 1'b1;
      display = {4{B}};

      // reset state, en=1 must not interfere
      step(1, 1, B, B, B, B, 16'hFFFF, 4'h0, 0, 0);
      step(1, 1, B, B, B, B, 16'hFFFF, 4'h0, 0, 0);
      // all blank: no update, locked on third sample
      step(0, 1, B, B, B, B, 16'hFFFF, 4'h0, 0, 0);
      step(0, 1, B, B, B, B, 16'hFFFF, 4'h0, 0, 0);
      step(0, 1, B, B, B, B, 16'hFFFF, 4'h0, 0, 1);
      step(0, 1, B, B, B, B, 16'hFFFF, 4'h0, 0, 1);

      // digit0 "3": commit on third sample, single upd pulse
      step(0, 1, B, B, B, THREE, 16'hFFFF, 4'h0, 0, 0);
      step(0, 1, B, B, B, THREE, 16'hFFFF, 4'h0, 0, 0);
      step(0, 1, B, B, B, THREE, 16'hFFF3, 4'h0, 1, 1);
      step(0, 1, B, B, B, THREE, 16'hFFF3, 4'h0, 0, 1);

      // digit1 toggling every cycle never commits
      for (int i = 0; i < 10; i++)
         step(0, 1, B, B, (i % 2 == 0) ? ZERO : ONE, THREE, 16'hFFF3, 4'h0, 0, 0);
      // back to blank: commit equals old value, so no pulse
      step(0, 1, B, B, B, THREE, 16'hFFF3, 4'h0, 0, 0);
      step(0, 1, B, B, B, THREE, 16'hFFF3, 4'h0, 0, 0);
      step(0, 1, B, B, B, THREE, 16'hFFF3, 4'h0, 0, 1);

      // digit2: all segments lit -> 8, then unrecognised -> 14 with err
      step(0, 1, B, EIGHT, B, THREE, 16'hFFF3, 4'h0, 0, 0);
      step(0, 1, B, EIGHT, B, THREE, 16'hFFF3, 4'h0, 0, 0);
      step(0, 1, B, EIGHT, B, THREE, 16'hF8F3, 4'h0, 1, 1);
      step(0, 1, B, BAD,   B, THREE, 16'hF8F3, 4'h0, 0, 0);
      step(0, 1, B, BAD,   B, THREE, 16'hF8F3, 4'h0, 0, 0);
      step(0, 1, B, BAD,   B, THREE, 16'hFEF3, 4'h4, 1, 1);
      step(0, 1, B, BAD,   B, THREE, 16'hFEF3, 4'h4, 0, 1);

      // digit0 back to blank
      step(0, 1, B, BAD, B, B, 16'hFEF3, 4'h4, 0, 0);
      step(0, 1, B, BAD, B, B, 16'hFEF3, 4'h4, 0, 0);
      step(0, 1, B, BAD, B, B, 16'hFEFF, 4'h4, 1, 1);

      // "3" for two samples, en=0 gap (display changes are ignored), then one more sample
      step(0, 1, B, BAD, B, THREE, 16'hFEFF, 4'h4, 0, 0);
      step(0, 1, B, BAD, B, THREE, 16'hFEFF, 4'h4, 0, 0);
      for (int i = 0; i < 5; i++)
         step(0, 0, B, BAD, B, (i == 2) ? BAD : THREE, 16'hFEFF, 4'h4, 0, 0);
      step(0, 1, B, BAD, B, THREE, 16'hFEF3, 4'h4, 1, 1);
      step(0, 1, B, BAD, B, THREE, 16'hFEF3, 4'h4, 0, 1);

      // reset mid-count: two "3" samples then reset, three fresh samples needed
      step(0, 1, B, BAD, B, B,     16'hFEF3, 4'h4, 0, 0);
      step(0, 1, B, BAD, B, THREE, 16'hFEF3, 4'h4, 0, 0);
      step(0, 1, B, BAD, B, THREE, 16'hFEF3, 4'h4, 0, 0);
      step(1, 1, B, BAD, B, THREE, 16'hFFFF, 4'h0, 0, 0);
      step(0, 1, B, BAD, B, THREE, 16'hFFFF, 4'h0, 0, 0);
      step(0, 1, B, BAD, B, THREE, 16'hFFFF, 4'h0, 0, 0);
      // digits 0 and 2 commit together: one pulse
      step(0, 1, B, BAD, B, THREE, 16'hFEF3, 4'h4, 1, 1);
      step(0, 1, B, BAD, B, THREE, 16'hFEF3, 4'h4, 0, 1);

      // let the monitor drain, bounded
      for (int i = 0; i < 20 && exp_q.size() > 0; i++)
         @(posedge clk);
      #3;
      chk("drain", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
